serial_add_ctrl: RTL and testbench

Bit-serial add/subtract sequencer that time-shares one full_adder cell across all bits of a WIDTH-bit operand pair, one bit per clock.
It latches the operands on a start request and feeds them LSB-first through the shared cell, keeping the carry in a flip-flop between cycles.
It then publishes sum, carry-out and signed overflow with a one-cycle done pulse.
It replaces a WIDTH-stage ripple chain of full_adder instances where area matters more than latency.

---
 rtl/serial_add_ctrl.sv | 105 ++++++++++
 tb/tb_serial_add_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one shared full_adder cell processes a
// WIDTH-bit operand pair LSB-first, one bit per clock, then publishes the result.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y,
  output logic co
);
  assign y  = a ^ b ^ c;
  assign co = (a & b) | (c & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] op_a, op_b, shreg;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_y, fa_co;
  logic             last_bit;

  full_adder u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .c  (carry),
    .y  (fa_y),
    .co (fa_co)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last_bit) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert B at load and seed the carry with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      shreg <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_a  <= a;
          op_b  <= b ^ {WIDTH{sub}};
          carry <= sub;
          cnt   <= '0;
        end
        RUN: begin
          shreg <= {fa_y, shreg[WIDTH-1:1]};
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_co;
          cnt   <= cnt + CW'(1);
          // On the MSB edge, carry still holds the carry into the MSB.
          if (last_bit) begin
            sum  <= {fa_y, shreg[WIDTH-1:1]};
            cout <= fa_co;
            ovf  <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomized and directed checks of serial_add_ctrl against an arithmetic model.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int tests = 0;
  int fails = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference model from plain integer arithmetic.
  task automatic model(input int ia, input int ib, input bit isub,
                       output logic [W-1:0] esum, output logic ecout, output logic eovf);
    int sa, sb, r, u;
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    r  = isub ? sa - sb : sa + sb;
    u  = isub ? ia - ib : ia + ib;
    esum  = W'(u & 255);
    ecout = isub ? (ia >= ib) : (u > 255);
    eovf  = (r > 127) || (r < -128);
  endtask

  // Drives one operation and collects what the DUT shows; checks happen in callers.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input bit isub,
                       output int lat, output int busy_cnt, output bit timed_out,
                       output logic [W-1:0] osum, output logic ocout, output logic oovf,
                       output logic done_next, output logic [W-1:0] sum_next);
    start = 1'b1; a = ia; b = ib; sub = isub;
    step();
    start = 1'b0;
    lat = 0; busy_cnt = 0; timed_out = 1'b0;
    while (!done && lat < W + 5) begin
      if (busy) busy_cnt++;
      step();
      lat++;
    end
    timed_out = !done;
    osum = sum; ocout = cout; oovf = ovf;
    step();
    done_next = done; sum_next = sum;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    step(); step();
    tests++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic check_op(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input bit isub);
    int lat, bc; bit to;
    logic [W-1:0] s, sn, es; logic c, o, dn, ec, eo;
    model(int'(ia), int'(ib), isub, es, ec, eo);
    do_op(ia, ib, isub, lat, bc, to, s, c, o, dn, sn);
    tests++;
    if (to) begin
      fails++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, W + 5);
    end
    tests++;
    if ({s, c, o} !== {es, ec, eo}) begin
      fails++;
      $display("FAIL %s_result: a=%h b=%h sub=%b got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
               name, ia, ib, isub, s, c, o, es, ec, eo);
    end
    tests++;
    if (lat !== W || bc !== W) begin
      fails++;
      $display("FAIL %s_latency: got done after %0d edges busy %0d cycles, want %0d/%0d",
               name, lat, bc, W, W);
    end
    tests++;
    if (dn !== 1'b0 || sn !== es) begin
      fails++;
      $display("FAIL %s_hold: got done=%b sum=%h next cycle, want done=0 sum=%h", name, dn, sn, es);
    end
  endtask

  task automatic test_directed();
    check_op("add_3c_55", 8'h3C, 8'h55, 1'b0);
    check_op("add_ff_01", 8'hFF, 8'h01, 1'b0);
    step(); step();
    tests++;
    if (sum !== 8'h00 || cout !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL idle_hold: got sum=%h cout=%b done=%b, want 00/1/0", sum, cout, done);
    end
    check_op("sub_10_20", 8'h10, 8'h20, 1'b1);
    check_op("sub_80_01", 8'h80, 8'h01, 1'b1);
    check_op("sub_eq", 8'h5A, 8'h5A, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      check_op("rand", W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
               bit'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_ignore_in_run();
    int dones = 0;
    logic [W-1:0] got = '0;
    start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0;
    step();
    start = 1'b0;
    step(); step();
    a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      if (done) begin dones++; got = sum; end
      step();
    end
    tests++;
    if (got !== 8'h02) begin
      fails++;
      $display("FAIL ignore_sum: got %h, want 02", got);
    end
    tests++;
    if (dones !== 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_single: got %0d done pulses busy=%b, want 1 and busy=0", dones, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    check_op("pre_abort", 8'h3C, 8'h55, 1'b0);
    start = 1'b1; a = 8'h0F; b = 8'h01; sub = 1'b0;
    step();
    start = 1'b0;
    step(); step(); step();
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL abort_async: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    step();
    rst = 1'b0;
    step();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: got busy=%b done=%b after release, want 0/0", busy, done);
    end
    check_op("post_abort", 8'h0F, 8'h01, 1'b0);
  endtask

  task automatic test_back_to_back();
    int last = -1, pulses = 0, bad_gap = 0, bad_val = 0;
    start = 1'b1; a = 8'h7F; b = 8'h01; sub = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (done) begin
        pulses++;
        if (last >= 0 && i - last != W + 2) bad_gap++;
        if (sum !== 8'h80 || cout !== 1'b0 || ovf !== 1'b1) bad_val++;
        last = i;
      end
    end
    start = 1'b0;
    tests++;
    if (pulses < 4 || bad_gap != 0) begin
      fails++;
      $display("FAIL b2b_period: got %0d pulses %0d bad gaps, want >=4 pulses every %0d cycles",
               pulses, bad_gap, W + 2);
    end
    tests++;
    if (bad_val != 0) begin
      fails++;
      $display("FAIL b2b_result: got %0d pulses with wrong result, want sum=80 cout=0 ovf=1 on each", bad_val);
    end
    for (int i = 0; i < W + 3; i++) step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_in_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
